pipe_adder_n: RTL

PIPE_ADDER_N -- requirements
Module: pipe_adder_n

---
 rtl/pipe_adder_n_if.sv | 27 ++
 rtl/pipe_adder_n.sv | 101 ++++++++++
 2 files changed

// File: rtl/pipe_adder_n_if.sv
// pipe_adder_n_if: operand/result handshake bundle
// for the segmented pipelined adder.
interface pipe_adder_n_if #(
   parameter int WIDTH = 64
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );
endinterface

// File: rtl/pipe_adder_n.sv
// pipe_adder_n: add/sub split into NSEG carry segments,
// one segment per stage, with a global stall.
module pipe_adder_n #(
   parameter int WIDTH = 64,
   parameter int SEG_W = 16
) (
   input  logic      clk,
   input  logic      rst,
   pipe_adder_n_if.slave bus
);
   localparam int NSEG = WIDTH / SEG_W;

   logic             adv;
   logic [WIDTH-1:0] eb;
   logic [SEG_W:0]   t;
   logic             ovf_d;
   logic             ovf_q;

   logic [WIDTH-1:0] a_q [NSEG];
   logic [WIDTH-1:0] b_q [NSEG];
   logic [WIDTH-1:0] s_q [NSEG];
   logic             c_q [NSEG];
   logic             v_q [NSEG];

   logic [WIDTH-1:0] a_d [NSEG];
   logic [WIDTH-1:0] b_d [NSEG];
   logic [WIDTH-1:0] s_d [NSEG];
   logic             c_d [NSEG];

   function automatic logic [SEG_W:0] seg_add(
      input logic [SEG_W-1:0] x,
      input logic [SEG_W-1:0] y,
      input logic             c
   );
      return {1'b0, x} + {1'b0, y} + {{SEG_W{1'b0}}, c};
   endfunction

   assign adv           = !v_q[NSEG-1] || bus.out_ready;
   assign bus.in_ready  = adv && !rst;
   assign bus.out_valid = v_q[NSEG-1];
   assign bus.sum       = s_q[NSEG-1];
   assign bus.cout      = c_q[NSEG-1];
   assign bus.ovf       = ovf_q;

   // Per-stage segment add; stage 0 folds in sub inversion
   always_comb begin
      eb    = bus.sub ? ~bus.b : bus.b;
      t     = '0;
      ovf_d = 1'b0;
      for (int k = 0; k < NSEG; k++) begin
         a_d[k] = '0;
         b_d[k] = '0;
         s_d[k] = '0;
         c_d[k] = 1'b0;
      end
      t = seg_add(bus.a[SEG_W-1:0], eb[SEG_W-1:0],
                  bus.sub | bus.cin);
      a_d[0] = bus.a;
      b_d[0] = eb;
      s_d[0][SEG_W-1:0] = t[SEG_W-1:0];
      c_d[0] = t[SEG_W];
      for (int k = 1; k < NSEG; k++) begin
         t = seg_add(a_q[k-1][k*SEG_W +: SEG_W],
                     b_q[k-1][k*SEG_W +: SEG_W],
                     c_q[k-1]);
         a_d[k] = a_q[k-1];
         b_d[k] = b_q[k-1];
         s_d[k] = s_q[k-1];
         s_d[k][k*SEG_W +: SEG_W] = t[SEG_W-1:0];
         c_d[k] = t[SEG_W];
      end
      ovf_d = (a_d[NSEG-1][WIDTH-1] == b_d[NSEG-1][WIDTH-1])
           && (s_d[NSEG-1][WIDTH-1] != a_d[NSEG-1][WIDTH-1]);
   end

   // Pipeline registers: clear on reset, shift only on advance
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NSEG; k++) begin
            a_q[k] <= '0;
            b_q[k] <= '0;
            s_q[k] <= '0;
            c_q[k] <= 1'b0;
            v_q[k] <= 1'b0;
         end
         ovf_q <= 1'b0;
      end else if (adv) begin
         v_q[0] <= bus.in_valid;
         for (int k = 1; k < NSEG; k++) begin
            v_q[k] <= v_q[k-1];
         end
         for (int k = 0; k < NSEG; k++) begin
            a_q[k] <= a_d[k];
            b_q[k] <= b_d[k];
            s_q[k] <= s_d[k];
            c_q[k] <= c_d[k];
         end
         ovf_q <= ovf_d;
      end
   end
endmodule
